master_bridge_axi_w_drain: RTL
==============================

Name: master_bridge_axi_w_drain

Overview:
- Read-side consumer of the master bridge async data FIFO, in the FIFO read clock domain.
- Takes one burst command (AXI4 AWLEN) at a time and pops exactly AWLEN+1 entries from the FIFO's first-word-fall-through read port.
- Drives them onto the AXI4 W channel through one registered output stage, with WLAST on the final beat.

Parameters:
- DATA_WIDTH, 32, AXI WDATA width in bits.
- STRB_WIDTH, DATA_WIDTH/8, AXI WSTRB width.
- ENTRY_WIDTH, DATA_WIDTH+STRB_WIDTH, FIFO entry width; packed {strb, data}.
- LEN_WIDTH, 8, AXI4 AxLEN width.

Ports:
- i_clk  in  1  FIFO read-domain clock; all logic on rising edge.
- i_rst  in  1  Synchronous active-high reset.
- i_cmd_valid  in  1  Burst command valid.
- o_cmd_ready  out  1  Command accepted when valid&ready.
- i_cmd_len  in  LEN_WIDTH  AWLEN; beats = len+1.
- i_fifo_empty  in  1  FIFO empty flag.
- o_fifo_rd_inc  out  1  FIFO pop strobe; combinational.
- i_fifo_rd_data  in  ENTRY_WIDTH  FIFO head entry; combinational, valid while !i_fifo_empty.
- o_wvalid  out  1  AXI WVALID.
- i_wready  in  1  AXI WREADY.
- o_wdata  out  DATA_WIDTH  AXI WDATA.
- o_wstrb  out  STRB_WIDTH  AXI WSTRB.
- o_wlast  out  1  AXI WLAST.
- o_burst_done  out  1  One-cycle pulse when the last beat handshakes.

Behaviour:
- Reset (i_rst=1 at an edge): state=IDLE, o_wvalid=0, o_wlast=0, o_wdata=0, o_wstrb=0, counters=0, o_burst_done=0. Reset takes priority over all events, including mid-burst.
- Reset mid-burst abandons the burst. FIFO contents not yet popped stay in the FIFO; clearing them is the FIFO owner's responsibility.
- FSM states:
  - IDLE: o_cmd_ready=1. On i_cmd_valid: latch len_q=i_cmd_len, clear issue_cnt, go to ISSUE.
  - ISSUE: o_cmd_ready=0. After the beat with issue_cnt==len_q is loaded, go to DRAIN.
  - DRAIN: o_cmd_ready=0. On o_wvalid&i_wready&o_wlast: pulse o_burst_done, go to IDLE.
- load = (state==ISSUE) & !i_fifo_empty & (!o_wvalid | i_wready).
- o_fifo_rd_inc = load. It is never asserted when i_fifo_empty=1, and never in IDLE or DRAIN.
- On load, registered at the next edge:
  - o_wdata = i_fifo_rd_data[DATA_WIDTH-1:0]
  - o_wstrb = i_fifo_rd_data[ENTRY_WIDTH-1:DATA_WIDTH]
  - o_wlast = (issue_cnt==len_q)
  - o_wvalid = 1
  - issue_cnt += 1
- No load and i_wready=1: o_wvalid falls to 0 and o_wlast to 0. o_wdata/o_wstrb hold their values.
- AXI rule: once o_wvalid=1, o_wvalid, o_wdata, o_wstrb and o_wlast stay stable until i_wready=1.
- Latency: a FIFO entry appears on W one cycle after its pop. The first beat of a burst can appear at the earliest 2 cycles after the command handshake.
- Throughput: 1 beat/cycle while the FIFO is non-empty and i_wready=1.
- issue_cnt is LEN_WIDTH+1 bits so len=255 (256 beats) never wraps. The comparison is against the zero-extended len_q.
- len=0: a single beat with o_wlast=1.
- Next command is accepted no earlier than the cycle after the o_burst_done pulse. Bursts never overlap.
- FIFO empty mid-burst: no pop. The output drains on i_wready, then o_wvalid=0 until data arrives. Beat order and count are preserved.
- Simultaneous handshake and load (o_wvalid=1, i_wready=1, FIFO non-empty): the next beat replaces the current one in the same edge, with no bubble.

Decomposition:
- Shared master bridge package/include holds:
  - AXI_LEN_WIDTH=8.
  - FSM state encoding (IDLE=2'd0, ISSUE=2'd1, DRAIN=2'd2).
  - Entry packing offsets (STRB_LSB=DATA_WIDTH).
- One sub-module: master_bridge_w_out_reg, a single-entry valid/ready output register holding data, strb and last. It exposes load and accept, with a synchronous active-high reset.
- FSM and counters stay in the top.

Test Plan:
- len=0, one entry preloaded {strb=4'hF, data=32'hDEADBEEF}, wready=1 -> one beat wdata=DEADBEEF, wstrb=F, wlast=1; o_burst_done pulses on that handshake; 1 pop total.
- len=3, FIFO holds 4 entries 0x1..0x4, wready=1 -> 4 beats on consecutive cycles; wlast only on 0x4; exactly 4 o_fifo_rd_inc pulses; o_cmd_ready low from the accept cycle until after o_burst_done.
- len=3, wready low for 3 cycles on beat 2 -> wvalid held, wdata=0x2 stable throughout; no pops during the stall; sequence 1,2,3,4 intact.
- len=2, FIFO empty for 5 cycles after beat 1 -> wvalid=0 in the gap, no rd_inc while empty; beats 2,3 follow when filled, wlast on beat 3.
- len=255, FIFO streaming, wready=1 -> exactly 256 beats, wlast only on beat 256, counter does not wrap.
- i_rst asserted after beat 2 of a len=7 burst -> next cycle: wvalid=0, wlast=0, state IDLE, o_cmd_ready=1; a new len=0 command completes normally.

Source files
------------

// File: rtl/master_bridge_axi_w_drain_pkg.sv
// Shared definitions for the master bridge W-channel drain: AXI length width,
// drain FSM encoding and FIFO entry packing helpers.
package master_bridge_axi_w_drain_pkg;

    localparam int AXI_LEN_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } drain_state_e;

    // FIFO entries are packed {strb, data}; strobes start right above the data.
    function automatic int strb_lsb(input int data_width);
        return data_width;
    endfunction

endpackage

// File: rtl/master_bridge_w_out_reg.sv
// Single-entry valid/ready output register carrying one W beat (data, strb, last).
// A load always wins, so a beat can be replaced in the same edge it is accepted.
module master_bridge_w_out_reg #(
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_load,
    input  logic                  i_accept,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [STRB_WIDTH-1:0] i_strb,
    input  logic                  i_last,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [STRB_WIDTH-1:0] o_strb,
    output logic                  o_last
);

    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [STRB_WIDTH-1:0] strb_q, strb_d;
    logic                  last_q, last_d;

    // Load a new beat, or retire the current one when it is accepted; data/strb hold.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        strb_d  = strb_q;
        last_d  = last_q;
        if (i_load) begin
            valid_d = 1'b1;
            data_d  = i_data;
            strb_d  = i_strb;
            last_d  = i_last;
        end else if (i_accept) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end
    end

    // Output stage registers with synchronous clear.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            strb_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            strb_q  <= strb_d;
            last_q  <= last_d;
        end
    end

    assign o_valid = valid_q;
    assign o_data  = data_q;
    assign o_strb  = strb_q;
    assign o_last  = last_q;

endmodule

// File: rtl/master_bridge_axi_w_drain.sv
// W-channel drain: accepts one AWLEN command at a time, pops len+1 entries from
// the FWFT async FIFO read port and presents them on AXI W through one register.
module master_bridge_axi_w_drain
    import master_bridge_axi_w_drain_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int STRB_WIDTH  = DATA_WIDTH / 8,
    parameter int ENTRY_WIDTH = DATA_WIDTH + STRB_WIDTH,
    parameter int LEN_WIDTH   = AXI_LEN_WIDTH
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_cmd_valid,
    output logic                   o_cmd_ready,
    input  logic [LEN_WIDTH-1:0]   i_cmd_len,
    input  logic                   i_fifo_empty,
    output logic                   o_fifo_rd_inc,
    input  logic [ENTRY_WIDTH-1:0] i_fifo_rd_data,
    output logic                   o_wvalid,
    input  logic                   i_wready,
    output logic [DATA_WIDTH-1:0]  o_wdata,
    output logic [STRB_WIDTH-1:0]  o_wstrb,
    output logic                   o_wlast,
    output logic                   o_burst_done
);

    localparam int STRB_LSB  = strb_lsb(DATA_WIDTH);
    // One extra bit so a 256-beat burst counts to 256 without wrapping.
    localparam int CNT_WIDTH = LEN_WIDTH + 1;

    drain_state_e         state_q, state_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [CNT_WIDTH-1:0] issue_cnt_q, issue_cnt_d;

    logic load;
    logic accept;
    logic beat_last;

    assign accept    = o_wvalid & i_wready;
    assign beat_last = (issue_cnt_q == {1'b0, len_q});

    // Next-state, counter and strobe logic for the command/issue/drain sequence.
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        issue_cnt_d  = issue_cnt_q;
        o_cmd_ready  = 1'b0;
        o_burst_done = 1'b0;
        load         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                o_cmd_ready = 1'b1;
                if (i_cmd_valid) begin
                    len_d       = i_cmd_len;
                    issue_cnt_d = '0;
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                load = !i_fifo_empty && (!o_wvalid || i_wready);
                if (load) begin
                    issue_cnt_d = issue_cnt_q + 1'b1;
                    if (beat_last) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (accept && o_wlast) begin
                    o_burst_done = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state, latched burst length and issued-beat counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            issue_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            issue_cnt_q <= issue_cnt_d;
        end
    end

    assign o_fifo_rd_inc = load;

    master_bridge_w_out_reg #(
        .DATA_WIDTH (DATA_WIDTH),
        .STRB_WIDTH (STRB_WIDTH)
    ) u_out_reg (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_load   (load),
        .i_accept (accept),
        .i_data   (i_fifo_rd_data[DATA_WIDTH-1:0]),
        .i_strb   (i_fifo_rd_data[ENTRY_WIDTH-1:STRB_LSB]),
        .i_last   (beat_last),
        .o_valid  (o_wvalid),
        .o_data   (o_wdata),
        .o_strb   (o_wstrb),
        .o_last   (o_wlast)
    );

endmodule
